// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates the single-ported VeriRISC memory between the CPU sequence
//   controller and a DMA/loader port. Requests are granted round-robin with
//   a one-cycle grant per beat; DMA bursts are capped at MAX_BURST beats so
//   the CPU fetch path always gets a turn. Read data returns one cycle after
//   the granted read beat, routed to whichever requester issued it.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   cpu_req_i/wr_i/addr_i/wdata_i CPU request (held until cpu_gnt_o)
//   cpu_gnt_o                     CPU beat accepted this cycle
//   cpu_rdata_o, cpu_rvalid_o     CPU read return (rdata is 0 when not valid)
//   dma_req_i/wr_i/addr_i/wdata_i DMA request (held until dma_gnt_o)
//   dma_last_i                    current DMA beat is the last of its burst
//   dma_gnt_o                     DMA beat accepted this cycle
//   dma_rdata_o, dma_rvalid_o     DMA read return (rdata is 0 when not valid)
//   mem_rd_o, mem_wr_o            memory strobes (never both high)
//   mem_addr_o, mem_wdata_o       memory address / write data
//   mem_rdata_i                   memory read data, valid the cycle after mem_rd_o
//
// State  | Meaning
// -------+-------------------------------------------------------------
// IDLE   | no grant; pick next requester (round-robin on a tie)
// CPU    | single CPU beat granted, then back to IDLE
// DMA    | DMA beat granted; stays for up to MAX_BURST consecutive beats

module mem_arbiter #(
    parameter int AWIDTH    = 5,
    parameter int DWIDTH    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              cpu_req_i,
    input  logic              cpu_wr_i,
    input  logic [AWIDTH-1:0] cpu_addr_i,
    input  logic [DWIDTH-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic [DWIDTH-1:0] cpu_rdata_o,
    output logic              cpu_rvalid_o,

    input  logic              dma_req_i,
    input  logic              dma_wr_i,
    input  logic [AWIDTH-1:0] dma_addr_i,
    input  logic [DWIDTH-1:0] dma_wdata_i,
    input  logic              dma_last_i,
    output logic              dma_gnt_o,
    output logic [DWIDTH-1:0] dma_rdata_o,
    output logic              dma_rvalid_o,

    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    input  logic [DWIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CPU  = 2'd1,
        S_DMA  = 2'd2
    } state_t;

    // Keep the beat counter at least one bit wide so MAX_BURST=1 still elaborates.
    localparam int              BW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0]   LAST_BEAT = BW'(MAX_BURST - 1);

    state_t        state_q, state_d;
    logic          last_dma_q, last_dma_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic [1:0]    rd_owner_q, rd_owner_d;   // [0] CPU read pending, [1] DMA read pending

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            last_dma_q <= 1'b1;              // CPU wins the first tie after reset
            beat_cnt_q <= '0;
            rd_owner_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            last_dma_q <= last_dma_d;
            beat_cnt_q <= beat_cnt_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_dma_d  = last_dma_q;
        beat_cnt_d  = beat_cnt_q;
        rd_owner_d  = 2'b00;
        cpu_gnt_o   = 1'b0;
        dma_gnt_o   = 1'b0;
        mem_rd_o    = 1'b0;
        mem_wr_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        case (state_q)
            S_IDLE: begin
                beat_cnt_d = '0;
                if (cpu_req_i && dma_req_i) begin
                    state_d = last_dma_q ? S_CPU : S_DMA;
                end else if (cpu_req_i) begin
                    state_d = S_CPU;
                end else if (dma_req_i) begin
                    state_d = S_DMA;
                end
            end

            S_CPU: begin
                state_d = S_IDLE;
                // A request withdrawn after selection is simply not granted.
                if (cpu_req_i) begin
                    cpu_gnt_o     = 1'b1;
                    mem_rd_o      = !cpu_wr_i;
                    mem_wr_o      = cpu_wr_i;
                    mem_addr_o    = cpu_addr_i;
                    mem_wdata_o   = cpu_wdata_i;
                    last_dma_d    = 1'b0;
                    rd_owner_d[0] = !cpu_wr_i;
                end
            end

            S_DMA: begin
                if (dma_req_i) begin
                    dma_gnt_o     = 1'b1;
                    mem_rd_o      = !dma_wr_i;
                    mem_wr_o      = dma_wr_i;
                    mem_addr_o    = dma_addr_i;
                    mem_wdata_o   = dma_wdata_i;
                    last_dma_d    = 1'b1;
                    rd_owner_d[1] = !dma_wr_i;
                    if (!dma_last_i && (beat_cnt_q != LAST_BEAT)) begin
                        state_d    = S_DMA;
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end else begin
                        state_d    = S_IDLE;
                        beat_cnt_d = '0;
                    end
                end else begin
                    // DMA withdrew its request mid-burst: no beat, burst ends.
                    state_d    = S_IDLE;
                    beat_cnt_d = '0;
                end
            end

            default: begin
                state_d    = S_IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    assign cpu_rvalid_o = rd_owner_q[0];
    assign dma_rvalid_o = rd_owner_q[1];
    assign cpu_rdata_o  = rd_owner_q[0] ? mem_rdata_i : '0;
    assign dma_rdata_o  = rd_owner_q[1] ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter (AWIDTH=5, DWIDTH=8, MAX_BURST=4) with a
//   small synchronous memory model on the memory side. A simple requester
//   driver retires CPU requests and advances DMA beats on each grant.

module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_wr, cpu_gnt, cpu_rvalid;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_wdata, cpu_rdata;
    logic       dma_req, dma_wr, dma_last, dma_gnt, dma_rvalid;
    logic [4:0] dma_addr;
    logic [7:0] dma_wdata, dma_rdata;
    logic       mem_rd, mem_wr;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;

    logic [7:0] mem [32];

    int n_checks = 0;
    int n_errors = 0;

    bit         auto_drv = 1'b1;
    int         dma_beat, dma_len, dma_last_idx;
    logic [4:0] dma_base;
    logic [7:0] dma_dbase;

    bit t2_cg [8]  = '{0, 1, 0, 0, 0, 1, 0, 0};
    bit t2_dg [8]  = '{0, 0, 0, 1, 0, 0, 0, 1};
    bit t3_cg [11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    bit t3_dg [11] = '{0, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0};
    bit t4_dg [10] = '{0, 1, 1, 0, 0, 1, 1, 1, 1, 0};

    always #5 clk = ~clk;

    mem_arbiter #(.AWIDTH(5), .DWIDTH(8), .MAX_BURST(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cpu_req_i    (cpu_req),
        .cpu_wr_i     (cpu_wr),
        .cpu_addr_i   (cpu_addr),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_gnt_o    (cpu_gnt),
        .cpu_rdata_o  (cpu_rdata),
        .cpu_rvalid_o (cpu_rvalid),
        .dma_req_i    (dma_req),
        .dma_wr_i     (dma_wr),
        .dma_addr_i   (dma_addr),
        .dma_wdata_i  (dma_wdata),
        .dma_last_i   (dma_last),
        .dma_gnt_o    (dma_gnt),
        .dma_rdata_o  (dma_rdata),
        .dma_rvalid_o (dma_rvalid),
        .mem_rd_o     (mem_rd),
        .mem_wr_o     (mem_wr),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    // Synchronous single-port memory: read data appears the cycle after mem_rd.
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_dma();
        dma_addr  = dma_base + 5'(dma_beat);
        dma_wdata = dma_dbase + 8'(dma_beat);
        dma_last  = (dma_beat == dma_last_idx);
    endtask

    task automatic dma_start(input logic [4:0] a, input logic [7:0] d, input int len,
                             input int last_idx, input logic wr);
        dma_base     = a;
        dma_dbase    = d;
        dma_len      = len;
        dma_last_idx = last_idx;
        dma_beat     = 0;
        dma_wr       = wr;
        set_dma();
        dma_req      = 1'b1;
    endtask

    // Called at a negedge; returns at the next negedge. Grants seen in the
    // current cycle retire the CPU request / advance the DMA beat just after
    // the edge.
    task automatic step();
        logic cg, dg;
        cg = cpu_gnt;
        dg = dma_gnt;
        @(posedge clk);
        #1;
        if (auto_drv) begin
            if (cg) cpu_req = 1'b0;
            if (dg) begin
                dma_beat++;
                if (dma_beat >= dma_len) dma_req = 1'b0;
                else set_dma();
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        cpu_req  = 1'b0;
        dma_req  = 1'b0;
        dma_last = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic cpu_access(input logic wr, input logic [4:0] a, input logic [7:0] d,
                              input logic [7:0] exp, input string tag);
        logic got;
        cpu_req   = 1'b1;
        cpu_wr    = wr;
        cpu_addr  = a;
        cpu_wdata = d;
        got       = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            step();
            got = cpu_gnt;
        end
        chk({tag, "_gnt"}, got, 1);
        step();
        cpu_req = 1'b0;
        if (!wr) begin
            chk({tag, "_rv"}, cpu_rvalid, 1);
            chk({tag, "_rd"}, cpu_rdata, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_wr = 1'b0; dma_addr = '0; dma_wdata = '0; dma_last = 1'b0;
        dma_beat = 0; dma_len = 0; dma_last_idx = 0; dma_base = '0; dma_dbase = '0;
        @(negedge clk);
        do_reset();

        // Preload the memory model through the arbiter.
        cpu_access(1'b1, 5'd5, 8'hA5, 8'h00, "pre5");
        cpu_access(1'b1, 5'd1, 8'h3C, 8'h00, "pre1");
        cpu_access(1'b1, 5'd2, 8'hC3, 8'h00, "pre2");

        // Reset state
        do_reset();
        chk("rst_cgnt", cpu_gnt, 0);
        chk("rst_dgnt", dma_gnt, 0);
        chk("rst_strb", {mem_rd, mem_wr}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_rv",   {cpu_rvalid, dma_rvalid}, 0);

        // Test 1: single CPU read of addr 5
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'd5;
        chk("t1_c1_gnt", cpu_gnt, 0);
        step();
        chk("t1_c2_gnt",  cpu_gnt, 1);
        chk("t1_c2_dgnt", dma_gnt, 0);
        chk("t1_c2_rd",   mem_rd, 1);
        chk("t1_c2_wr",   mem_wr, 0);
        chk("t1_c2_addr", mem_addr, 5);
        step();
        chk("t1_c3_rv",   cpu_rvalid, 1);
        chk("t1_c3_rd",   cpu_rdata, 8'hA5);
        chk("t1_c3_drv",  dma_rvalid, 0);
        chk("t1_c3_gnt",  cpu_gnt, 0);

        // Test 2: simultaneous requests held continuously -> CPU first, alternate
        do_reset();
        auto_drv = 1'b0;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'd1;
        dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 5'd2; dma_last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_cg_%0d", i + 1), cpu_gnt, t2_cg[i]);
            chk($sformatf("t2_dg_%0d", i + 1), dma_gnt, t2_dg[i]);
            chk($sformatf("t2_rw_%0d", i + 1), mem_rd & mem_wr, 0);
            if (i == 2) chk("t2_c3_crd", {cpu_rvalid, cpu_rdata}, {1'b1, 8'h3C});
            if (i == 4) chk("t2_c5_drd", {dma_rvalid, dma_rdata}, {1'b1, 8'hC3});
            if (i < 7) step();
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        auto_drv = 1'b1;
        step();
        step();

        // Test 3: 6-beat DMA write burst split at 4, CPU read served in between
        do_reset();
        for (int i = 0; i < 11; i++) begin
            if (i == 0) dma_start(5'd0, 8'h10, 6, 5, 1'b1);
            if (i == 1) begin cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'd5; end
            chk($sformatf("t3_cg_%0d", i + 1), cpu_gnt, t3_cg[i]);
            chk($sformatf("t3_dg_%0d", i + 1), dma_gnt, t3_dg[i]);
            if (i == 6) chk("t3_c7_mem", {mem_rd, mem_wr, mem_addr}, {2'b10, 5'd5});
            if (i == 7) chk("t3_c8_crd", {cpu_rvalid, cpu_rdata}, {1'b1, 8'hA5});
            if (i == 8) chk("t3_c9_mem", {mem_wr, mem_addr, mem_wdata}, {1'b1, 5'd4, 8'h14});
            step();
        end
        for (int k = 0; k < 6; k++)
            cpu_access(1'b0, 5'(k), 8'h00, 8'h10 + 8'(k), $sformatf("t3_rb%0d", k));

        // Test 4: DMA drops request after 2 beats; fresh burst gets a full 4
        for (int i = 0; i < 10; i++) begin
            if (i == 0) dma_start(5'd16, 8'h40, 2, 3, 1'b1);
            if (i == 4) dma_start(5'd20, 8'h50, 6, 7, 1'b1);
            chk($sformatf("t4_dg_%0d", i + 1), dma_gnt, t4_dg[i]);
            if (i == 5) chk("t4_c6_addr", mem_addr, 20);
            if (i == 9) dma_req = 1'b0;
            step();
        end

        // Test 5: reset mid-burst with a DMA read return pending
        dma_start(5'd0, 8'h00, 6, 7, 1'b0);
        chk("t5_c1_dg", dma_gnt, 0);
        step();
        chk("t5_c2_dg", dma_gnt, 1);
        step();
        chk("t5_c3_dg", dma_gnt, 1);
        chk("t5_c3_drd", {dma_rvalid, dma_rdata}, {1'b1, 8'h10});
        rst = 1'b1;
        step();
        chk("t5_c4_gnt",  {cpu_gnt, dma_gnt}, 0);
        chk("t5_c4_rv",   {cpu_rvalid, dma_rvalid}, 0);
        chk("t5_c4_strb", {mem_rd, mem_wr}, 0);
        rst = 1'b0;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'd3;
        step();
        chk("t5_c5_cg", cpu_gnt, 1);
        chk("t5_c5_dg", dma_gnt, 0);
        step();
        chk("t5_c6_crd", {cpu_rvalid, cpu_rdata}, {1'b1, 8'h13});
        step();
        chk("t5_c7_dg",   dma_gnt, 1);
        chk("t5_c7_addr", mem_addr, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
